change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Hopper-side executor for change owed by the vending controller.
- Accepts a change amount in quarters, then pulses the quarter-hopper motor once per coin.
- Confirms each coin on the hopper's coin-passed sensor; reports completion, jams and empty-hopper faults back to the controller.
- Sits between the vending FSM's change output and the physical hopper driver.

Parameters:
- AMT_W, 4, width of amount/count fields in quarters (max 15 quarters).
- TIMEOUT_CYC, 50, clk cycles the motor may run without a sense edge before a jam is declared.
- GAP_CYC, 8, motor-off cycles between consecutive coins.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  start request; sampled only in IDLE.
- amount  in  AMT_W  quarters to dispense; captured with req.
- hopper_sense  in  1  coin-passed sensor, asynchronous; high while a coin is in the chute.
- hopper_empty  in  1  low-level switch; high means no coins.
- fault_clr  in  1  clears FAULT.
- motor  out  1  quarter-hopper drive.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on successful completion.
- jam  out  1  sticky; set on timeout.
- empty_err  out  1  sticky; set on hopper empty.
- remaining  out  AMT_W  coins still owed.
- dispensed  out  AMT_W  coins confirmed this request.

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0; sync flops 0; timers 0.
- hopper_sense passes through a 2-flop synchronizer. A rising edge is detected on the synced value (third flop), giving 3-cycle latency from pin to event.
- IDLE:
  - req=1 and amount=0 -> done pulses next cycle; stay IDLE.
  - req=1 and amount>0 -> capture remaining=amount, clear dispensed, go CHECK.
- CHECK (1 cycle):
  - hopper_empty=1 -> empty_err=1, go FAULT.
  - Otherwise go DRIVE with timer=0.
- DRIVE:
  - motor=1; timer increments each cycle.
  - Sense event -> motor=0 next cycle; remaining-1, dispensed+1.
    - If new remaining=0 -> DONE.
    - Else -> GAP.
  - timer reaches TIMEOUT_CYC-1 with no event -> jam=1, motor=0, go FAULT.
  - If a sense event and the timeout coincide in the same cycle, the event wins.
- GAP:
  - motor=0 for exactly GAP_CYC cycles, then CHECK.
  - Sense events during GAP are ignored: they are bounce, not counted.
- DONE: done=1 for one cycle, busy=0 next cycle, return IDLE. remaining=0 and dispensed stay valid until the next req.
- FAULT:
  - motor=0, busy=1; remaining holds the coins still owed.
  - fault_clr=1 -> clear jam and empty_err, go IDLE (request abandoned).
- req while busy is ignored, with no queuing.
- remaining and dispensed never wrap: decrements occur only when remaining>0.
- Reset mid-DRIVE drops motor asynchronously.

Optional Feature:
- Macro: DOLLAR_HOPPER_EN.
- Defined:
  - Adds ports motor_dollar (out, 1), hopper_sense_dollar (in, 1) and hopper_empty_dollar (in, 1).
  - While remaining>=4, CHECK selects the dollar hopper: DRIVE runs motor_dollar, its own synchronizer is used, and a confirmed coin subtracts 4 from remaining and adds 4 to dispensed.
  - If hopper_empty_dollar=1 while remaining>=4, the quarter hopper is used instead; no fault is raised.
  - Jam timeout applies per hopper.
- Undefined: the extra ports are absent; quarters only.

Test Plan:
1. req with amount=3, sense pulsed ~5 cycles after each motor rise -> three motor pulses, each separated by 8 off cycles; dispensed=3, remaining=0; done pulses once.
2. req with amount=2, sense never asserted -> motor high for exactly 50 cycles, then jam=1, remaining=2, busy=1; fault_clr -> IDLE with jam=0.
3. req with amount=4, hopper_empty rises after the second coin -> empty_err=1, dispensed=2, remaining=2; motor never restarts.
4. req with amount=0 -> done pulse; motor never asserted; busy stays 0.
5. rst_n low mid-DRIVE with amount=5 -> motor=0 immediately; all outputs 0; second req with amount=1 completes normally.
6. DOLLAR_HOPPER_EN defined, amount=6 -> one motor_dollar pulse, then two quarter pulses; dispensed=6.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser: drives the quarter hopper once per owed coin and confirms each coin on the sense input.
// Define DOLLAR_HOPPER_EN to add a dollar hopper that pays 4 quarters per confirmed coin.
module change_dispenser #(
   parameter int AMT_W       = 4,
   parameter int TIMEOUT_CYC = 50,
   parameter int GAP_CYC     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef DOLLAR_HOPPER_EN
   input  logic             hopper_sense_dollar,
   input  logic             hopper_empty_dollar,
   output logic             motor_dollar,
`endif
   input  logic             req,
   input  logic [AMT_W-1:0] amount,
   input  logic             hopper_sense,
   input  logic             hopper_empty,
   input  logic             fault_clr,
   output logic             motor,
   output logic             busy,
   output logic             done,
   output logic             jam,
   output logic             empty_err,
   output logic [AMT_W-1:0] remaining,
   output logic [AMT_W-1:0] dispensed
);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] CHECK = 3'd1;
   localparam logic [2:0] DRIVE = 3'd2;
   localparam logic [2:0] GAP   = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;
   localparam logic [2:0] FAULT = 3'd5;
   localparam int TW = $clog2(TIMEOUT_CYC + GAP_CYC);

   logic [2:0]       state;
   logic [TW-1:0]    timer;
   logic [2:0]       sq;
   logic             motor_on;
   logic             sel;
   logic             ev;
   logic             ev_d;
   logic             dol_ok;
   logic [AMT_W-1:0] step;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sq <= '0;
      else        sq <= {sq[1:0], hopper_sense};

`ifdef DOLLAR_HOPPER_EN
   logic [2:0] sd;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sd <= '0;
      else        sd <= {sd[1:0], hopper_sense_dollar};
   assign ev_d         = sd[1] & ~sd[2];
   assign dol_ok       = remaining >= AMT_W'(4) && !hopper_empty_dollar;
   assign motor_dollar = motor_on & sel;
`else
   assign ev_d   = 1'b0;
   assign dol_ok = 1'b0;
`endif

   assign ev    = sel ? ev_d : sq[1] & ~sq[2];
   assign step  = sel ? AMT_W'(4) : AMT_W'(1);
   assign motor = motor_on & ~sel;
   assign busy  = state != IDLE;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= IDLE;
         timer     <= '0;
         motor_on  <= 1'b0;
         sel       <= 1'b0;
         done      <= 1'b0;
         jam       <= 1'b0;
         empty_err <= 1'b0;
         remaining <= '0;
         dispensed <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE:
               if (req && amount == '0) done <= 1'b1;
               else if (req) begin
                  remaining <= amount;
                  dispensed <= '0;
                  state     <= CHECK;
               end
            CHECK: begin
               timer     <= '0;
               sel       <= dol_ok;
               motor_on  <= dol_ok | ~hopper_empty;
               empty_err <= ~dol_ok & hopper_empty;
               state     <= (dol_ok | ~hopper_empty) ? DRIVE : FAULT;
            end
            DRIVE:
               if (ev) begin
                  motor_on <= 1'b0;
                  timer    <= '0;
                  if (remaining >= step) begin
                     remaining <= remaining - step;
                     dispensed <= dispensed + step;
                  end
                  done  <= remaining <= step;
                  state <= (remaining <= step) ? DONE : GAP;
               end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
                  jam      <= 1'b1;
                  motor_on <= 1'b0;
                  state    <= FAULT;
               end else timer <= timer + 1'b1;
            // the CHECK cycle is the last of the GAP_CYC motor-off cycles
            GAP:
               if (timer == TW'(GAP_CYC - 2)) state <= CHECK;
               else timer <= timer + 1'b1;
            DONE: state <= IDLE;
            FAULT:
               if (fault_clr) begin
                  jam       <= 1'b0;
                  empty_err <= 1'b0;
                  state     <= IDLE;
               end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed scenarios for change_dispenser with a cycle-accurate hopper responder.
module tb_change_dispenser;
   logic       clk = 1'b0;
   logic       rst_n, req, hopper_sense, hopper_empty, fault_clr;
   logic [3:0] amount;
   logic       motor, busy, done, jam, empty_err;
   logic [3:0] remaining, dispensed;
`ifdef DOLLAR_HOPPER_EN
   logic       hopper_sense_dollar, hopper_empty_dollar, motor_dollar;
`endif

   int checks = 0, errors = 0;
   int pulses, d_pulses, done_cnt, busy_cnt, min_on, max_on, min_gap, max_gap, on_run, gap_run;

   always #5 clk = ~clk;

   change_dispenser dut (
      .clk(clk),
      .rst_n(rst_n),
`ifdef DOLLAR_HOPPER_EN
      .hopper_sense_dollar(hopper_sense_dollar),
      .hopper_empty_dollar(hopper_empty_dollar),
      .motor_dollar(motor_dollar),
`endif
      .req(req),
      .amount(amount),
      .hopper_sense(hopper_sense),
      .hopper_empty(hopper_empty),
      .fault_clr(fault_clr),
      .motor(motor),
      .busy(busy),
      .done(done),
      .jam(jam),
      .empty_err(empty_err),
      .remaining(remaining),
      .dispensed(dispensed)
   );

   // Runs n cycles; the hopper raises sense for 3 cycles once the motor has been high dly samples.
   task automatic run(input int n, input int dly, input int empty_after);
      int hold = 0, dhold = 0, d_on = 0;
      logic pm = 1'b0, pd = 1'b0;
      pulses = 0; d_pulses = 0; done_cnt = 0; busy_cnt = 0;
      min_on = 1000; max_on = 0; min_gap = 1000; max_gap = 0; on_run = 0; gap_run = 0;
      hopper_sense = 1'b0;
`ifdef DOLLAR_HOPPER_EN
      hopper_sense_dollar = 1'b0;
`endif
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (done) done_cnt++;
         if (busy) busy_cnt++;
         if (motor && !pm) begin
            if (pulses > 0) begin
               min_gap = gap_run < min_gap ? gap_run : min_gap;
               max_gap = gap_run > max_gap ? gap_run : max_gap;
            end
            pulses++;
            on_run = 0;
         end
         if (!motor && pm) begin
            min_on = on_run < min_on ? on_run : min_on;
            max_on = on_run > max_on ? on_run : max_on;
            gap_run = 0;
            if (pulses == empty_after) hopper_empty = 1'b1;
         end
         if (motor) on_run++; else gap_run++;
         if (motor && on_run == dly) begin hopper_sense = 1'b1; hold = 3; end
         else if (hold > 0) begin hold--; if (hold == 0) hopper_sense = 1'b0; end
         pm = motor;
`ifdef DOLLAR_HOPPER_EN
         if (motor_dollar && !pd) begin d_pulses++; d_on = 0; end
         if (motor_dollar) d_on++;
         if (motor_dollar && d_on == dly) begin hopper_sense_dollar = 1'b1; dhold = 3; end
         else if (dhold > 0) begin dhold--; if (dhold == 0) hopper_sense_dollar = 1'b0; end
         pd = motor_dollar;
`endif
      end
   endtask

   task automatic start(input logic [3:0] a);
      req = 1'b1; amount = a;
      @(posedge clk); #1;
      req = 1'b0;
   endtask

   task automatic clear_fault();
      fault_clr = 1'b1;
      @(posedge clk); #1;
      fault_clr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if ({motor, busy, done, jam, empty_err} !== 5'b0) begin errors++; $display("FAIL reset flags: got %b want 00000", {motor, busy, done, jam, empty_err}); end
      checks++; if ({remaining, dispensed} !== 8'h00) begin errors++; $display("FAIL reset counts: got %h want 00", {remaining, dispensed}); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset idle busy: got %b want 0", busy); end
   endtask

   task automatic test_three_coins();
      start(4'd3);
      run(60, 5, -1);
      checks++; if (pulses !== 3) begin errors++; $display("FAIL t1 pulses: got %0d want 3", pulses); end
      checks++; if (min_on !== 7 || max_on !== 7) begin errors++; $display("FAIL t1 on len: got %0d..%0d want 7", min_on, max_on); end
      checks++; if (min_gap !== 8 || max_gap !== 8) begin errors++; $display("FAIL t1 gap: got %0d..%0d want 8", min_gap, max_gap); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL t1 done count: got %0d want 1", done_cnt); end
      checks++; if (dispensed !== 4'd3 || remaining !== 4'd0) begin errors++; $display("FAIL t1 counts: got disp %0d rem %0d want 3 0", dispensed, remaining); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1 busy: got %b want 0", busy); end
   endtask

   task automatic test_jam();
      start(4'd2);
      run(80, -1, -1);
      checks++; if (pulses !== 1 || max_on !== 50) begin errors++; $display("FAIL t2 motor: got %0d pulses len %0d want 1 len 50", pulses, max_on); end
      checks++; if (jam !== 1'b1 || busy !== 1'b1 || motor !== 1'b0) begin errors++; $display("FAIL t2 fault: got jam %b busy %b motor %b want 1 1 0", jam, busy, motor); end
      checks++; if (remaining !== 4'd2 || dispensed !== 4'd0) begin errors++; $display("FAIL t2 counts: got rem %0d disp %0d want 2 0", remaining, dispensed); end
      clear_fault();
      checks++; if (jam !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t2 clear: got jam %b busy %b want 0 0", jam, busy); end
   endtask

   task automatic test_timeout_edge();
      start(4'd1);
      run(80, 48, -1);
      checks++; if (jam !== 1'b0 || done_cnt !== 1 || dispensed !== 4'd1) begin errors++; $display("FAIL event wins: got jam %b done %0d disp %0d want 0 1 1", jam, done_cnt, dispensed); end
      checks++; if (max_on !== 50) begin errors++; $display("FAIL event wins len: got %0d want 50", max_on); end
      start(4'd1);
      run(80, 49, -1);
      checks++; if (jam !== 1'b1 || dispensed !== 4'd0 || remaining !== 4'd1) begin errors++; $display("FAIL late event: got jam %b disp %0d rem %0d want 1 0 1", jam, dispensed, remaining); end
      clear_fault();
   endtask

   task automatic test_empty();
      start(4'd4);
      run(60, 5, 2);
      checks++; if (pulses !== 2 || motor !== 1'b0) begin errors++; $display("FAIL t3 pulses: got %0d motor %b want 2 0", pulses, motor); end
      checks++; if (empty_err !== 1'b1 || busy !== 1'b1 || jam !== 1'b0) begin errors++; $display("FAIL t3 flags: got empty %b busy %b jam %b want 1 1 0", empty_err, busy, jam); end
      checks++; if (dispensed !== 4'd2 || remaining !== 4'd2) begin errors++; $display("FAIL t3 counts: got disp %0d rem %0d want 2 2", dispensed, remaining); end
      clear_fault();
      hopper_empty = 1'b0;
      checks++; if (empty_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t3 clear: got empty %b busy %b want 0 0", empty_err, busy); end
   endtask

   task automatic test_zero();
      start(4'd0);
      checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL t4 done: got done %b busy %b want 1 0", done, busy); end
      run(10, 5, -1);
      checks++; if (pulses !== 0 || busy_cnt !== 0 || done_cnt !== 0) begin errors++; $display("FAIL t4 idle: got pulses %0d busy %0d done %0d want 0 0 0", pulses, busy_cnt, done_cnt); end
   endtask

   task automatic test_back_to_back();
      req = 1'b1; amount = 4'd2;
      @(posedge clk); #1;
      amount = 4'd9;
      @(posedge clk); #1;
      req = 1'b0;
      run(60, 5, -1);
      checks++; if (pulses !== 2 || dispensed !== 4'd2 || done_cnt !== 1) begin errors++; $display("FAIL busy req: got pulses %0d disp %0d done %0d want 2 2 1", pulses, dispensed, done_cnt); end
      start(4'd1);
      run(30, 5, -1);
      checks++; if (pulses !== 1 || dispensed !== 4'd1 || remaining !== 4'd0) begin errors++; $display("FAIL next req: got pulses %0d disp %0d rem %0d want 1 1 0", pulses, dispensed, remaining); end
   endtask

   task automatic test_reset_mid_drive();
      start(4'd5);
      run(18, 5, -1);
      checks++; if (motor !== 1'b1 || remaining !== 4'd4 || dispensed !== 4'd1) begin errors++; $display("FAIL t5 pre: got motor %b rem %0d disp %0d want 1 4 1", motor, remaining, dispensed); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({motor, busy, done, jam, empty_err} !== 5'b0 || {remaining, dispensed} !== 8'h00) begin errors++; $display("FAIL t5 async: got %b %h want 00000 00", {motor, busy, done, jam, empty_err}, {remaining, dispensed}); end
      @(negedge clk); rst_n = 1'b1;
      req = 1'b1; amount = 4'd1;
      @(posedge clk); #1;
      req = 1'b0;
      run(30, 5, -1);
      checks++; if (pulses !== 1 || dispensed !== 4'd1 || remaining !== 4'd0 || done_cnt !== 1) begin errors++; $display("FAIL t5 after: got pulses %0d disp %0d rem %0d done %0d want 1 1 0 1", pulses, dispensed, remaining, done_cnt); end
   endtask

`ifdef DOLLAR_HOPPER_EN
   task automatic test_dollar();
      start(4'd6);
      run(80, 5, -1);
      checks++; if (d_pulses !== 1 || pulses !== 2) begin errors++; $display("FAIL t6 pulses: got dollar %0d quarter %0d want 1 2", d_pulses, pulses); end
      checks++; if (dispensed !== 4'd6 || remaining !== 4'd0 || done_cnt !== 1) begin errors++; $display("FAIL t6 counts: got disp %0d rem %0d done %0d want 6 0 1", dispensed, remaining, done_cnt); end
   endtask
`endif

   initial begin
      req = 1'b0; amount = '0; hopper_sense = 1'b0; hopper_empty = 1'b0; fault_clr = 1'b0;
`ifdef DOLLAR_HOPPER_EN
      hopper_sense_dollar = 1'b0; hopper_empty_dollar = 1'b0;
`endif
      test_reset();
      test_three_coins();
      test_jam();
      test_timeout_edge();
      test_empty();
      test_zero();
      test_back_to_back();
      test_reset_mid_drive();
`ifdef DOLLAR_HOPPER_EN
      test_dollar();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
